// File: rtl/friscv_axil_ram.sv
// AXI4-lite data memory responder: single-ported word RAM with byte-lane writes,
// independent read/write channels, one outstanding transaction per direction.
module friscv_axil_ram #(
  parameter int          AXI_ADDR_W = 32,
  parameter int          AXI_ID_W   = 8,
  parameter int          AXI_DATA_W = 32,
  parameter int          RAM_DEPTH  = 1024,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    srst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [AXI_ADDR_W-1:0]   awaddr,
  input  logic [2:0]              awprot,
  input  logic [AXI_ID_W-1:0]     awid,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [AXI_DATA_W-1:0]   wdata,
  input  logic [AXI_DATA_W/8-1:0] wstrb,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [AXI_ID_W-1:0]     bid,
  output logic [1:0]              bresp,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [AXI_ADDR_W-1:0]   araddr,
  input  logic [2:0]              arprot,
  input  logic [AXI_ID_W-1:0]     arid,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [AXI_ID_W-1:0]     rid,
  output logic [1:0]              rresp,
  output logic [AXI_DATA_W-1:0]   rdata
);

  localparam int STRB_W = AXI_DATA_W / 8;
  localparam int OFFS_W = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(RAM_DEPTH);
  localparam logic [AXI_ADDR_W-1:0] BASE_A  = AXI_ADDR_W'(BASE_ADDR);
  localparam logic [AXI_ADDR_W-1:0] DEPTH_A = AXI_ADDR_W'(RAM_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {IDLE, RESP} state_t;

  state_t wr_state, rd_state;

  logic [AXI_DATA_W-1:0] ram [RAM_DEPTH];

  logic                  aw_full, w_full;
  logic [AXI_ID_W-1:0]   aw_id_q;
  logic [IDX_W-1:0]      aw_idx_q;
  logic                  aw_ok_q;
  logic [AXI_DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;

  logic [AXI_ADDR_W-1:0] aw_word, ar_word;
  logic                  aw_ok, ar_ok;
  logic                  wr_commit;
  logic                  unused_prot;

  // The subtraction wraps below BASE_ADDR, so the lower bound is checked separately
  assign aw_word = (awaddr - BASE_A) >> OFFS_W;
  assign ar_word = (araddr - BASE_A) >> OFFS_W;
  assign aw_ok   = (awaddr >= BASE_A) && (aw_word < DEPTH_A);
  assign ar_ok   = (araddr >= BASE_A) && (ar_word < DEPTH_A);

  assign wr_commit   = (wr_state == IDLE) && aw_full && w_full;
  assign unused_prot = ^{awprot, arprot};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state <= IDLE;
      aw_full  <= 1'b0;
      w_full   <= 1'b0;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bid      <= '0;
      bresp    <= '0;
    end else if (srst) begin
      wr_state <= IDLE;
      aw_full  <= 1'b0;
      w_full   <= 1'b0;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bid      <= '0;
      bresp    <= '0;
    end else begin
      case (wr_state)
        IDLE: begin
          if (wr_commit) begin
            wr_state <= RESP;
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b1;
            bid      <= aw_id_q;
            bresp    <= aw_ok_q ? RESP_OKAY : RESP_SLVERR;
          end else begin
            if (awvalid && awready) begin
              aw_full <= 1'b1;
              awready <= 1'b0;
            end else begin
              awready <= !aw_full;
            end
            if (wvalid && wready) begin
              w_full <= 1'b1;
              wready <= 1'b0;
            end else begin
              wready <= !w_full;
            end
          end
        end
        RESP: begin
          if (bvalid && bready) begin
            wr_state <= IDLE;
            bvalid   <= 1'b0;
            awready  <= 1'b1;
            wready   <= 1'b1;
          end
        end
      endcase
    end
  end

  // Slot payloads and RAM contents deliberately have no reset
  always_ff @(posedge aclk) begin
    if (awvalid && awready) begin
      aw_id_q  <= awid;
      aw_idx_q <= aw_word[IDX_W-1:0];
      aw_ok_q  <= aw_ok;
    end
    if (wvalid && wready) begin
      w_data_q <= wdata;
      w_strb_q <= wstrb;
    end
    if (wr_commit && aw_ok_q && !srst) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (w_strb_q[i]) ram[aw_idx_q][i*8 +: 8] <= w_data_q[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state <= IDLE;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rid      <= '0;
      rresp    <= '0;
      rdata    <= '0;
    end else if (srst) begin
      rd_state <= IDLE;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rid      <= '0;
      rresp    <= '0;
      rdata    <= '0;
    end else begin
      case (rd_state)
        IDLE: begin
          if (arvalid && arready) begin
            rd_state <= RESP;
            arready  <= 1'b0;
            rvalid   <= 1'b1;
            rid      <= arid;
            rresp    <= ar_ok ? RESP_OKAY : RESP_SLVERR;
            rdata    <= ar_ok ? ram[ar_word[IDX_W-1:0]] : '0;
          end else begin
            arready <= 1'b1;
          end
        end
        RESP: begin
          if (rvalid && rready) begin
            rd_state <= IDLE;
            rvalid   <= 1'b0;
            arready  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_friscv_axil_ram.sv
// Directed self-checking bench for friscv_axil_ram: handshake timing, byte lanes,
// range errors, backpressure, read-before-write and mid-transaction reset.
module tb_friscv_axil_ram;

  logic        aclk, aresetn, srst;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic [7:0]  awid;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [7:0]  bid;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic [7:0]  arid;
  logic        rvalid, rready;
  logic [7:0]  rid;
  logic [1:0]  rresp;
  logic [31:0] rdata;

  int total_cnt = 0;
  int bad_cnt   = 0;

  logic [56:0] all_out;
  assign all_out = {awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rresp, rdata};

  friscv_axil_ram dut (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot), .awid(awid),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot), .arid(arid),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rresp(rresp), .rdata(rdata)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic waitWriteResp(output logic [1:0] resp, output logic [7:0] rsp_id);
    logic got = 1'b0;
    resp = 2'bxx;
    rsp_id = 8'hxx;
    for (int c = 0; c < 20 && !got; c++) begin
      if (bvalid) begin
        got = 1'b1;
        resp = bresp;
        rsp_id = bid;
      end
      @(negedge aclk);
    end
    checkOutput("wr_resp_seen", got, 1);
  endtask

  task automatic writeWord(input logic [31:0] addr, input logic [7:0] id, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp, output logic [7:0] rsp_id);
    logic aw_done = 1'b0, w_done = 1'b0, aw_hs, w_hs;
    awaddr = addr; awid = id; awvalid = 1'b1;
    wdata = data; wstrb = strb; wvalid = 1'b1;
    for (int c = 0; c < 20 && !(aw_done && w_done); c++) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(negedge aclk);
      if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin wvalid  = 1'b0; w_done  = 1'b1; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    checkOutput("wr_accept", {aw_done, w_done}, 2'b11);
    waitWriteResp(resp, rsp_id);
  endtask

  task automatic readWord(input logic [31:0] addr, input logic [7:0] id, output logic [31:0] data,
                          output logic [1:0] resp, output logic [7:0] rsp_id);
    logic done = 1'b0, hs, got = 1'b0;
    araddr = addr; arid = id; arvalid = 1'b1;
    data = 'x; resp = 'x; rsp_id = 'x;
    for (int c = 0; c < 20 && !done; c++) begin
      hs = arvalid && arready;
      @(negedge aclk);
      if (hs) begin arvalid = 1'b0; done = 1'b1; end
    end
    arvalid = 1'b0;
    checkOutput("rd_accept", done, 1);
    for (int c = 0; c < 20 && !got; c++) begin
      if (rvalid) begin
        got = 1'b1;
        data = rdata; resp = rresp; rsp_id = rid;
      end
      @(negedge aclk);
    end
    checkOutput("rd_resp_seen", got, 1);
  endtask

  initial begin
    logic [1:0]  resp;
    logic [7:0]  rsp_id;
    logic [31:0] data;

    aresetn = 1'b0; srst = 1'b0;
    awvalid = 1'b0; awaddr = '0; awprot = '0; awid = '0;
    wvalid = 1'b0; wdata = '0; wstrb = '0;
    arvalid = 1'b0; araddr = '0; arprot = '0; arid = '0;
    bready = 1'b1; rready = 1'b1;

    // Reset values and registered ready rise
    repeat (3) @(negedge aclk);
    checkOutput("reset_outs", all_out, 0);
    aresetn = 1'b1;
    @(negedge aclk);
    checkOutput("ready_after_rst", {awready, wready, arready}, 3'b111);

    // AW and W in the same cycle; response two cycles after the handshake
    awaddr = 32'h10; awid = 8'd3; awvalid = 1'b1;
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    checkOutput("t1_bvalid_early", bvalid, 0);
    @(negedge aclk);
    checkOutput("t1_bresp", {bvalid, bid, bresp}, {1'b1, 8'd3, 2'b00});
    @(negedge aclk);
    checkOutput("t1_bvalid_clear", bvalid, 0);
    araddr = 32'h10; arid = 8'd5; arvalid = 1'b1;
    @(negedge aclk);
    arvalid = 1'b0;
    checkOutput("t1_rresp", {rvalid, rid, rresp, rdata}, {1'b1, 8'd5, 2'b00, 32'hDEADBEEF});
    @(negedge aclk);
    checkOutput("t1_rvalid_clear", rvalid, 0);

    // W ahead of AW by four cycles, single byte lane
    wdata = 32'h0000AA00; wstrb = 4'h2; wvalid = 1'b1;
    @(negedge aclk);
    wvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("t2_held_ready", {wready, awready, bvalid}, 3'b010);
      @(negedge aclk);
    end
    awaddr = 32'h10; awid = 8'd7; awvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0;
    waitWriteResp(resp, rsp_id);
    checkOutput("t2_bresp", {rsp_id, resp}, {8'd7, 2'b00});
    readWord(32'h10, 8'd1, data, resp, rsp_id);
    checkOutput("t2_merge", {resp, data}, {2'b00, 32'hDEADAAEF});

    // Out of range access at BASE_ADDR + RAM_DEPTH*4
    writeWord(32'h0, 8'd1, 32'h01010101, 4'hF, resp, rsp_id);
    writeWord(32'hFFC, 8'd2, 32'h12345678, 4'hF, resp, rsp_id);
    checkOutput("t3_last_ok", resp, 2'b00);
    readWord(32'h1000, 8'd9, data, resp, rsp_id);
    checkOutput("t3_rd_slverr", {rsp_id, resp, data}, {8'd9, 2'b10, 32'h0});
    writeWord(32'h1000, 8'd8, 32'hCAFEF00D, 4'hF, resp, rsp_id);
    checkOutput("t3_wr_slverr", {rsp_id, resp}, {8'd8, 2'b10});
    readWord(32'hFFC, 8'd2, data, resp, rsp_id);
    checkOutput("t3_neighbour", {resp, data}, {2'b00, 32'h12345678});
    readWord(32'h0, 8'd2, data, resp, rsp_id);
    checkOutput("t3_word0", {resp, data}, {2'b00, 32'h01010101});

    // Backpressure on both response channels
    bready = 1'b0; rready = 1'b0;
    awaddr = 32'h30; awid = 8'h09; awvalid = 1'b1;
    wdata = 32'h55AA55AA; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 32'h10; arid = 8'h0A; arvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge aclk);
    for (int i = 0; i < 10; i++) begin
      checkOutput("t4_stall",
                  {bvalid, bid, bresp, rvalid, rid, rresp, rdata, awready, wready, arready},
                  {1'b1, 8'h09, 2'b00, 1'b1, 8'h0A, 2'b00, 32'hDEADAAEF, 3'b000});
      @(negedge aclk);
    end
    bready = 1'b1; rready = 1'b1;
    @(negedge aclk);
    checkOutput("t4_release", {bvalid, rvalid, awready, wready, arready}, 5'b00111);
    readWord(32'h30, 8'd3, data, resp, rsp_id);
    checkOutput("t4_readback", {resp, data}, {2'b00, 32'h55AA55AA});

    // Read handshake on the commit edge sees the old word
    writeWord(32'h20, 8'd1, 32'h11111111, 4'hF, resp, rsp_id);
    awaddr = 32'h20; awid = 8'd4; awvalid = 1'b1;
    wdata = 32'h22222222; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h20; arid = 8'd6; arvalid = 1'b1;
    @(negedge aclk);
    arvalid = 1'b0;
    checkOutput("t5_same_cycle", {bvalid, rvalid, rid, rdata}, {1'b1, 1'b1, 8'd6, 32'h11111111});
    @(negedge aclk);
    readWord(32'h20, 8'd6, data, resp, rsp_id);
    checkOutput("t5_after", data, 32'h22222222);

    // Async reset while a write response and a read are pending
    bready = 1'b0; rready = 1'b0;
    awaddr = 32'h40; awid = 8'd4; awvalid = 1'b1;
    wdata = 32'h0BADCAFE; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge aclk);
    checkOutput("t6_bvalid_pending", bvalid, 1);
    araddr = 32'h10; arid = 8'd2; arvalid = 1'b1;
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    checkOutput("t6_rst_outs", all_out, 0);
    arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
    @(negedge aclk);
    checkOutput("t6_rst_hold", all_out, 0);
    aresetn = 1'b1;
    @(negedge aclk);
    checkOutput("t6_after_rst", {awready, wready, arready, bvalid, rvalid}, 5'b11100);
    @(negedge aclk);
    checkOutput("t6_no_stale", {bvalid, rvalid}, 2'b00);
    readWord(32'h40, 8'd7, data, resp, rsp_id);
    checkOutput("t6_committed", {resp, data}, {2'b00, 32'h0BADCAFE});

    // Synchronous reset behaves like aresetn
    srst = 1'b1;
    @(negedge aclk);
    checkOutput("srst_outs", all_out, 0);
    srst = 1'b0;
    @(negedge aclk);
    checkOutput("srst_release", {awready, wready, arready}, 3'b111);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/friscv_axil_ram.md
Name: friscv_axil_ram

Overview:
- AXI4-lite responder (slave) modelling the data memory that the processing unit's load/store path drives.
- Single-ported word RAM with byte-lane writes, independent read and write channels, and an address range check that returns SLVERR.
- Sits on the data-bus side of the infrastructure, or directly under the core in simulation and small FPGA builds.
- Exactly one outstanding transaction per direction.

Parameters:
AXI_ADDR_W, 32, address width of AW/AR
AXI_ID_W, 8, ID width; IDs are echoed, never interpreted
AXI_DATA_W, 32, data width; power of two, >= 32
RAM_DEPTH, 1024, number of AXI_DATA_W words; power of two
BASE_ADDR, 0, byte address mapped to word 0

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
srst  in  1  synchronous active-high reset; same effect as aresetn
awvalid  in  1  write address valid
awready  out  1  write address ready
awaddr  in  AXI_ADDR_W  write byte address
awprot  in  3  ignored
awid  in  AXI_ID_W  write ID
wvalid  in  1  write data valid
wready  out  1  write data ready
wdata  in  AXI_DATA_W  write data
wstrb  in  AXI_DATA_W/8  byte enables
bvalid  out  1  write response valid
bready  in  1  write response ready
bid  out  AXI_ID_W  echoed awid
bresp  out  2  0=OKAY, 2=SLVERR
arvalid  in  1  read address valid
arready  out  1  read address ready
araddr  in  AXI_ADDR_W  read byte address
arprot  in  3  ignored
arid  in  AXI_ID_W  read ID
rvalid  out  1  read data valid
rready  in  1  read data ready
rid  out  AXI_ID_W  echoed arid
rresp  out  2  0=OKAY, 2=SLVERR
rdata  out  AXI_DATA_W  read data

Behaviour:
- Reset (aresetn low or srst high):
  - All outputs are 0; both FSMs go to IDLE; holding slots are emptied.
  - RAM contents are not reset.
  - awready, wready and arready are registered and rise on the first cycle after reset release.
- Address decode:
  - off = addr - BASE_ADDR.
  - idx = off >> log2(AXI_DATA_W/8); the low offset bits are ignored.
  - Access is in range iff addr >= BASE_ADDR and idx < RAM_DEPTH.
- Write path. AW and W each have a one-entry holding slot and are accepted independently, in either order or in the same cycle.
  - awready = AW slot empty and write FSM in IDLE; wready = W slot empty and write FSM in IDLE.
- Write FSM states: IDLE, RESP.
  - IDLE -> RESP on the cycle both slots are full.
    - That cycle commits the write: for each byte lane i with wstrb[i]=1, RAM[idx] lane i <= wdata lane i. Out-of-range: no write.
    - Next cycle: bvalid=1, bid=held awid, bresp=0 (or 2 if out of range). Both slots are cleared.
  - RESP -> IDLE on bvalid&&bready. bvalid/bid/bresp stay stable until then; ready signals reassert the following cycle.
  - wstrb=0 is legal: no bytes change, response is OKAY.
- Read FSM states: IDLE, RESP.
  - arready = 1 in IDLE.
  - On arvalid&&arready: capture arid and the range check, and read RAM[idx] (registered, read-before-write).
    - rvalid=1 on the next cycle with rid=arid and rresp=0, or rresp=2 and rdata=0 if out of range.
  - RESP -> IDLE on rvalid&&rready. rdata/rid/rresp are stable while rvalid=1 and rready=0.
- Concurrency:
  - Read and write FSMs are independent; minimum round trip is 2 cycles per direction.
  - Read handshake in the same cycle as a write commit to the same idx returns the old data.
  - A read handshake one or more cycles after the commit returns the new data.
- Reset mid-transaction: any pending response is dropped (bvalid/rvalid go 0) and held AW/W are discarded. A write already committed stays in RAM.

Test Plan:
- Reset, then AW(addr=0x10, id=3) and W(0xDEADBEEF, strb=0xF) in the same cycle -> bvalid 2 cycles later, bid=3, bresp=0. Then AR(0x10, id=5) -> rvalid next cycle, rdata=0xDEADBEEF, rid=5, rresp=0.
- W issued 4 cycles before AW (addr=0x10, strb=0x2, data=0x0000AA00) -> wready drops after W accepted, awready stays 1. After AW, memory word reads 0xDEADAAEF.
- Out of range: AR at BASE_ADDR+RAM_DEPTH*4 -> rresp=2, rdata=0. Write to the same address -> bresp=2, and RAM is unchanged (check via a neighbouring in-range read).
- Backpressure: hold bready=0 and rready=0 for 10 cycles -> bvalid/rvalid, bid/rid, bresp/rresp and rdata are all stable. awready, wready and arready stay 0 until the response handshake completes.
- Same-cycle AR and write commit to addr 0x20 (old 0x11111111, new 0x22222222) -> read returns 0x11111111. Next read returns 0x22222222.
- Assert aresetn low while bvalid=1 and an AR is pending -> all outputs 0 during reset. After release, awready=wready=arready=1 and no stale bvalid/rvalid appear.
